// File: rtl/wbs_sram_pipe_if.sv
// Pipelined Wishbone-style slave bus carrying 32-bit word addresses and
// 16-bit data. The master drives requests; the slave returns ack, stall
// and read data.
interface wbs_sram_pipe_if;
    logic [31:0] wbs_address;
    logic [15:0] wbs_writedata;
    logic [15:0] wbs_readdata;
    logic        wbs_strobe;
    logic        wbs_cycle;
    logic        wbs_write;
    logic        wbs_ack;
    logic        wbs_stall;

    modport master (
        output wbs_address, wbs_writedata, wbs_strobe, wbs_cycle, wbs_write,
        input  wbs_readdata, wbs_ack, wbs_stall
    );

    modport slave (
        input  wbs_address, wbs_writedata, wbs_strobe, wbs_cycle, wbs_write,
        output wbs_readdata, wbs_ack, wbs_stall
    );
endinterface

// File: rtl/wbs_sram_pipe.sv
// Pipelined SRAM slave: 2^AW x 16-bit memory behind a fixed-latency
// response shift register, with optional periodic stall injection.
// Writes land in memory on the accept edge; reads sample memory on the
// accept edge and the data rides the pipeline to the ack.
module wbs_sram_pipe #(
    parameter int AW          = 10,
    parameter int LATENCY     = 3,
    parameter int STALL_EVERY = 0
) (
    input  logic          clk,
    input  logic          reset,
    wbs_sram_pipe_if.slave bus
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((STALL_EVERY > 0) ? STALL_EVERY - 1 : 0);

    logic [15:0]         mem [DEPTH];
    logic [15:0]         data_pipe [LATENCY];
    logic [LATENCY-1:0]  valid_reg;
    logic [LATENCY-1:0]  wr_reg;
    logic [CW-1:0]       cnt_reg;
    logic                stall_reg;
    logic [AW-1:0]       addr;
    logic                accept;
    logic                unused_addr_bits;

    // Upper address bits are deliberately ignored so addresses alias.
    assign addr             = bus.wbs_address[AW-1:0];
    assign unused_addr_bits = ^bus.wbs_address[31:AW];

    // Stall is a register output, so accept never loops combinationally
    // back through the stall path.
    assign accept = bus.wbs_cycle & bus.wbs_strobe & ~stall_reg & ~reset;

    // Memory array with registered read into the first response stage;
    // later data stages need no reset because valid_reg qualifies them.
    always_ff @(posedge clk) begin
        if (accept && bus.wbs_write) begin
            mem[addr] <= bus.wbs_writedata;
        end
        if (accept && !bus.wbs_write) begin
            data_pipe[0] <= mem[addr];
        end
        for (int i = 1; i < LATENCY; i++) begin
            data_pipe[i] <= data_pipe[i-1];
        end
    end

    // Valid / write-flag shift register; dropping cycle aborts everything
    // still in flight while leaving completed memory writes intact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
            wr_reg    <= '0;
        end else begin
            wr_reg[0] <= bus.wbs_write;
            for (int i = 1; i < LATENCY; i++) begin
                wr_reg[i] <= wr_reg[i-1];
            end
            if (!bus.wbs_cycle) begin
                valid_reg <= '0;
            end else begin
                valid_reg[0] <= accept;
                for (int i = 1; i < LATENCY; i++) begin
                    valid_reg[i] <= valid_reg[i-1];
                end
            end
        end
    end

    // Stall injection: after every STALL_EVERY accepts, refuse exactly one
    // cycle. The count restarts whenever the bus cycle is abandoned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg   <= '0;
            stall_reg <= 1'b0;
        end else if (!bus.wbs_cycle) begin
            cnt_reg   <= '0;
            stall_reg <= 1'b0;
        end else begin
            stall_reg <= 1'b0;
            if (STALL_EVERY != 0 && accept) begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_reg   <= '0;
                    stall_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign bus.wbs_ack       = valid_reg[LATENCY-1];
    assign bus.wbs_stall     = stall_reg;
    assign bus.wbs_readdata  = (valid_reg[LATENCY-1] && !wr_reg[LATENCY-1])
                               ? data_pipe[LATENCY-1] : 16'h0000;

endmodule

// File: tb/tb_wbs_sram_pipe.sv
// Directed bench for wbs_sram_pipe: one DUT without stall injection and one
// with STALL_EVERY=4, both LATENCY=3, AW=10.
module tb_wbs_sram_pipe;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    int   idle_bad = 0;

    int          acc0_q[$];
    int          ack0_cyc_q[$];
    logic [15:0] ack0_dat_q[$];
    int          acc1_q[$];
    int          ack1_cyc_q[$];
    int          stall1_q[$];

    always #5 clk = ~clk;

    wbs_sram_pipe_if bus0 ();
    wbs_sram_pipe_if bus1 ();

    wbs_sram_pipe #(.AW(10), .LATENCY(3), .STALL_EVERY(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    wbs_sram_pipe #(.AW(10), .LATENCY(3), .STALL_EVERY(4)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Observe both buses mid-cycle; accepts are logged against the edge count
    // preceding the accepting edge.
    always @(negedge clk) begin
        if (bus0.wbs_ack === 1'b1) begin
            ack0_cyc_q.push_back(cyc_cnt);
            ack0_dat_q.push_back(bus0.wbs_readdata);
        end else if (bus0.wbs_readdata !== 16'h0000) begin
            idle_bad++;
        end
        if (!reset && bus0.wbs_cycle && bus0.wbs_strobe && bus0.wbs_stall === 1'b0)
            acc0_q.push_back(cyc_cnt);
        if (bus1.wbs_ack === 1'b1) ack1_cyc_q.push_back(cyc_cnt);
        if (bus1.wbs_stall === 1'b1) stall1_q.push_back(cyc_cnt);
        if (!reset && bus1.wbs_cycle && bus1.wbs_strobe && bus1.wbs_stall === 1'b0)
            acc1_q.push_back(cyc_cnt);
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic clear_q();
        acc0_q.delete(); ack0_cyc_q.delete(); ack0_dat_q.delete();
        acc1_q.delete(); ack1_cyc_q.delete(); stall1_q.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue0(input logic wr, input logic [31:0] a, input logic [15:0] d);
        bus0.wbs_cycle = 1'b1; bus0.wbs_strobe = 1'b1; bus0.wbs_write = wr;
        bus0.wbs_address = a; bus0.wbs_writedata = d;
        @(posedge clk); #1;
    endtask

    task automatic issue1(input logic wr, input logic [31:0] a, input logic [15:0] d);
        int n;
        n = 0;
        bus1.wbs_cycle = 1'b1; bus1.wbs_strobe = 1'b1; bus1.wbs_write = wr;
        bus1.wbs_address = a; bus1.wbs_writedata = d;
        @(negedge clk);
        while (bus1.wbs_stall === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL stall_bound got stalled %0d cycles expected fewer than 20", n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        wait_cycles(2);
        checks++; if (bus0.wbs_ack !== 1'b0) begin errors++; $display("FAIL rst_ack0 got %b expected 0", bus0.wbs_ack); end
        checks++; if (bus0.wbs_stall !== 1'b0) begin errors++; $display("FAIL rst_stall0 got %b expected 0", bus0.wbs_stall); end
        checks++; if (bus0.wbs_readdata !== 16'h0) begin errors++; $display("FAIL rst_rdata0 got %h expected 0000", bus0.wbs_readdata); end
        checks++; if (bus1.wbs_ack !== 1'b0) begin errors++; $display("FAIL rst_ack1 got %b expected 0", bus1.wbs_ack); end
        checks++; if (bus1.wbs_stall !== 1'b0) begin errors++; $display("FAIL rst_stall1 got %b expected 0", bus1.wbs_stall); end
        reset = 1'b0;
        wait_cycles(1);
    endtask

    task automatic test_write_burst();
        int nz;
        logic [7:0] b;
        clear_q();
        for (int a = 0; a < 32; a++) begin
            b = 8'(a);
            issue0(1'b1, 32'(a), {b, b});
        end
        bus0.wbs_strobe = 1'b0;
        wait_cycles(6);
        checks++; if (ack0_cyc_q.size() != 32) begin errors++; $display("FAIL wr_ack_count got %0d expected 32", ack0_cyc_q.size()); end
        if (ack0_cyc_q.size() == 32 && acc0_q.size() == 32) begin
            checks++; if (ack0_cyc_q[0] - acc0_q[0] != 3) begin errors++; $display("FAIL wr_first_latency got %0d expected 3", ack0_cyc_q[0] - acc0_q[0]); end
            checks++; if (ack0_cyc_q[31] - ack0_cyc_q[0] != 31) begin errors++; $display("FAIL wr_ack_span got %0d expected 31", ack0_cyc_q[31] - ack0_cyc_q[0]); end
        end
        nz = 0;
        foreach (ack0_dat_q[i]) if (ack0_dat_q[i] !== 16'h0) nz++;
        checks++; if (nz != 0) begin errors++; $display("FAIL wr_ack_rdata got %0d nonzero expected 0", nz); end
        $display("write burst: %0d acks", ack0_cyc_q.size());
    endtask

    task automatic test_readback();
        logic [7:0] b;
        clear_q();
        for (int a = 0; a < 32; a++) issue0(1'b0, 32'(a), 16'h0);
        bus0.wbs_strobe = 1'b0;
        wait_cycles(6);
        checks++; if (ack0_dat_q.size() != 32) begin errors++; $display("FAIL rd_ack_count got %0d expected 32", ack0_dat_q.size()); end
        for (int a = 0; a < 32 && a < ack0_dat_q.size(); a++) begin
            b = 8'(a);
            checks++;
            if (ack0_dat_q[a] !== {b, b}) begin
                errors++; $display("FAIL rd_data[%0d] got %h expected %h", a, ack0_dat_q[a], {b, b});
            end
        end
        $display("readback: %0d acks", ack0_dat_q.size());
    endtask

    task automatic test_wrap();
        clear_q();
        issue0(1'b1, 32'h5, 16'hBEEF);
        issue0(1'b0, 32'h405, 16'h0);
        bus0.wbs_strobe = 1'b0;
        wait_cycles(6);
        checks++; if (ack0_dat_q.size() != 2) begin errors++; $display("FAIL wrap_count got %0d expected 2", ack0_dat_q.size()); end
        if (ack0_dat_q.size() == 2) begin
            checks++; if (ack0_dat_q[0] !== 16'h0) begin errors++; $display("FAIL wrap_wr_rdata got %h expected 0000", ack0_dat_q[0]); end
            checks++; if (ack0_dat_q[1] !== 16'hBEEF) begin errors++; $display("FAIL wrap_rd_data got %h expected beef", ack0_dat_q[1]); end
        end
        $display("wrap: read 0x405 after write 0x5");
    endtask

    task automatic test_abort();
        clear_q();
        for (int a = 1; a <= 3; a++) issue0(1'b0, 32'(a), 16'h0);
        bus0.wbs_strobe = 1'b0;
        bus0.wbs_cycle  = 1'b0;
        wait_cycles(10);
        checks++; if (ack0_dat_q.size() != 1) begin errors++; $display("FAIL abort_ack_count got %0d expected 1", ack0_dat_q.size()); end
        if (ack0_dat_q.size() >= 1) begin
            checks++; if (ack0_dat_q[0] !== 16'h0101) begin errors++; $display("FAIL abort_data got %h expected 0101", ack0_dat_q[0]); end
        end
        bus0.wbs_cycle = 1'b1;
        $display("abort: %0d acks", ack0_dat_q.size());
    endtask

    task automatic test_stall();
        clear_q();
        for (int a = 0; a < 32; a++) issue1(1'b0, 32'(a), 16'h0);
        bus1.wbs_strobe = 1'b0;
        wait_cycles(6);
        checks++; if (acc1_q.size() != 32) begin errors++; $display("FAIL stall_acc_count got %0d expected 32", acc1_q.size()); end
        checks++; if (ack1_cyc_q.size() != 32) begin errors++; $display("FAIL stall_ack_count got %0d expected 32", ack1_cyc_q.size()); end
        checks++; if (stall1_q.size() != 8) begin errors++; $display("FAIL stall_count got %0d expected 8", stall1_q.size()); end
        if (acc1_q.size() == 32 && stall1_q.size() == 8) begin
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (stall1_q[j] != acc1_q[4*j+3] + 1) begin
                    errors++; $display("FAIL stall_pos[%0d] got %0d expected %0d", j, stall1_q[j], acc1_q[4*j+3] + 1);
                end
            end
            checks++; if (acc1_q[31] - acc1_q[0] != 38) begin errors++; $display("FAIL stall_span got %0d expected 38", acc1_q[31] - acc1_q[0]); end
        end
        $display("stall: %0d accepts %0d stalls %0d acks", acc1_q.size(), stall1_q.size(), ack1_cyc_q.size());
    endtask

    task automatic test_stall_abort();
        clear_q();
        issue1(1'b0, 32'h0, 16'h0);
        issue1(1'b0, 32'h1, 16'h0);
        bus1.wbs_strobe = 1'b0;
        bus1.wbs_cycle  = 1'b0;
        wait_cycles(2);
        for (int a = 0; a < 4; a++) issue1(1'b0, 32'(a), 16'h0);
        bus1.wbs_strobe = 1'b0;
        wait_cycles(6);
        checks++; if (ack1_cyc_q.size() != 4) begin errors++; $display("FAIL sabort_ack_count got %0d expected 4", ack1_cyc_q.size()); end
        checks++; if (stall1_q.size() != 1) begin errors++; $display("FAIL sabort_stall_count got %0d expected 1", stall1_q.size()); end
        if (stall1_q.size() == 1 && acc1_q.size() == 6) begin
            checks++; if (stall1_q[0] != acc1_q[5] + 1) begin errors++; $display("FAIL sabort_stall_pos got %0d expected %0d", stall1_q[0], acc1_q[5] + 1); end
        end
        bus1.wbs_cycle = 1'b0;
        $display("stall abort: %0d stalls %0d acks", stall1_q.size(), ack1_cyc_q.size());
    endtask

    task automatic test_reset_midburst();
        int rel_cyc;
        clear_q();
        issue0(1'b0, 32'h10, 16'h0);
        issue0(1'b0, 32'h11, 16'h0);
        bus0.wbs_strobe = 1'b0;
        wait_cycles(1);
        checks++; if (bus0.wbs_ack !== 1'b1) begin errors++; $display("FAIL mid_pre_ack got %b expected 1", bus0.wbs_ack); end
        reset = 1'b1;
        #1;
        checks++; if (bus0.wbs_ack !== 1'b0) begin errors++; $display("FAIL mid_async_ack got %b expected 0", bus0.wbs_ack); end
        checks++; if (bus0.wbs_readdata !== 16'h0) begin errors++; $display("FAIL mid_async_rdata got %h expected 0000", bus0.wbs_readdata); end
        wait_cycles(2);
        checks++; if (ack0_cyc_q.size() != 0) begin errors++; $display("FAIL mid_reset_acks got %0d expected 0", ack0_cyc_q.size()); end
        reset = 1'b0;
        clear_q();
        rel_cyc = cyc_cnt;
        issue0(1'b0, 32'h10, 16'h0);
        issue0(1'b0, 32'h405, 16'h0);
        bus0.wbs_strobe = 1'b0;
        wait_cycles(6);
        checks++; if (ack0_dat_q.size() != 2) begin errors++; $display("FAIL post_ack_count got %0d expected 2", ack0_dat_q.size()); end
        if (ack0_dat_q.size() == 2 && acc0_q.size() == 2) begin
            checks++; if (acc0_q[0] != rel_cyc) begin errors++; $display("FAIL post_first_accept got %0d expected %0d", acc0_q[0], rel_cyc); end
            checks++; if (ack0_cyc_q[0] - acc0_q[0] != 3) begin errors++; $display("FAIL post_latency got %0d expected 3", ack0_cyc_q[0] - acc0_q[0]); end
            checks++; if (ack0_dat_q[0] !== 16'h1010) begin errors++; $display("FAIL post_data0 got %h expected 1010", ack0_dat_q[0]); end
            checks++; if (ack0_dat_q[1] !== 16'hBEEF) begin errors++; $display("FAIL post_data1 got %h expected beef", ack0_dat_q[1]); end
        end
        $display("reset mid-burst: %0d acks after release", ack0_dat_q.size());
    endtask

    task automatic test_idle_readdata();
        checks++;
        if (idle_bad != 0) begin errors++; $display("FAIL idle_rdata got %0d nonzero samples expected 0", idle_bad); end
    endtask

    initial begin
        bus0.wbs_cycle = 1'b0; bus0.wbs_strobe = 1'b0; bus0.wbs_write = 1'b0;
        bus0.wbs_address = 32'h0; bus0.wbs_writedata = 16'h0;
        bus1.wbs_cycle = 1'b0; bus1.wbs_strobe = 1'b0; bus1.wbs_write = 1'b0;
        bus1.wbs_address = 32'h0; bus1.wbs_writedata = 16'h0;
        test_reset();
        test_write_burst();
        test_readback();
        test_wrap();
        test_abort();
        test_stall();
        test_stall_abort();
        test_reset_midburst();
        test_idle_readdata();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wbs_sram_pipe.md
WBS_SRAM_PIPE -- requirements
Module: wbs_sram_pipe

Interface
REQ-001 SHALL have parameter AW, default 10, meaning word-address bits decoded (memory = 2^AW x 16-bit words).
REQ-002 SHALL have parameter LATENCY, default 3, legal 1..8, meaning accept-to-ack delay in clocks.
REQ-003 SHALL have parameter STALL_EVERY, default 0, meaning a one-cycle stall is injected after every STALL_EVERY accepted requests; 0 disables injection.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 wbs_address  in  32  word address; only bits [AW-1:0] are decoded.
REQ-007 wbs_writedata  in  16  write data.
REQ-008 wbs_readdata  out  16  read data, valid only while wbs_ack=1.
REQ-009 wbs_strobe  in  1  request valid.
REQ-010 wbs_cycle  in  1  bus cycle in progress.
REQ-011 wbs_write  in  1  1=write, 0=read.
REQ-012 wbs_ack  out  1  one-cycle completion pulse per accepted request.
REQ-013 wbs_stall  out  1  request not accepted this cycle.

Function
REQ-014 SHALL accept a request on a rising edge where wbs_cycle & wbs_strobe & !wbs_stall; at most one request per clock.
REQ-015 SHALL ignore wbs_strobe while wbs_cycle=0.
REQ-016 Accepted write SHALL update mem[wbs_address[AW-1:0]] on the accept edge.
REQ-017 Accepted read SHALL capture mem[wbs_address[AW-1:0]] on the accept edge; a read accepted the cycle after a write to the same address SHALL return the new data.
REQ-018 Addresses >= 2^AW SHALL wrap (upper bits ignored), with no error signalling.
REQ-019 Response path SHALL be a LATENCY-stage shift register of {valid, data}; a request accepted at edge N SHALL raise wbs_ack for exactly the one cycle following edge N+LATENCY-1.
REQ-020 Acks SHALL be returned in acceptance order, one per accepted request; back-to-back accepts SHALL give back-to-back acks.
REQ-021 wbs_readdata SHALL be 16'h0000 whenever wbs_ack=0 and for write acks.
REQ-022 Stall injection: a counter SHALL count accepted requests; when it reaches STALL_EVERY it SHALL clear and wbs_stall SHALL be 1 for exactly the next cycle; wbs_stall SHALL otherwise be 0.
REQ-023 wbs_stall SHALL be registered and SHALL NOT depend combinationally on inputs.
REQ-024 Deassertion of wbs_cycle SHALL flush all pending valid bits on the next edge (abort); no ack SHALL appear for flushed requests, and memory writes already accepted SHALL remain.
REQ-025 Stall counter SHALL reset to 0 on abort.
REQ-026 An accept and a flush on the same edge are impossible (accept requires wbs_cycle=1); an accept and an ack on the same edge SHALL both proceed.

Reset
REQ-027 While reset=1: wbs_ack=0, wbs_stall=0, wbs_readdata=0, all pipeline valid bits 0, stall counter 0, asynchronously.
REQ-028 Memory contents SHALL NOT be cleared by reset; reads of never-written locations return undefined data.
REQ-029 Reset asserted mid-burst SHALL discard all pending acks; first accept is possible on the first edge after reset deasserts.

Verification
REQ-030 LATENCY=3: write 0x0000..0x001F with data {2{addr[7:0]}} back-to-back -> 32 acks, first ack 3 cycles after first accept, no gaps.
REQ-031 Read back 0x0000..0x001F -> 32 acks in order, readdata 16'h0000, 16'h0101, ... 16'h1F1F.
REQ-032 STALL_EVERY=4, continuous strobe -> wbs_stall high one cycle after every 4th accept; exactly 32 acks for 32 requests.
REQ-033 Write 0xBEEF to addr 0x5, then read addr 0x405 (AW=10) -> readdata 16'hBEEF.
REQ-034 Issue 3 reads, drop wbs_cycle the cycle after the last accept -> at most acks already in the cycle before the drop; none afterwards.
REQ-035 Assert reset with 2 requests in flight -> wbs_ack=0 immediately, no acks after release; memory data written before reset still readable.
